// File: rtl/k423_if_bpu_upd_ctrl.sv
// k423_if_bpu_upd_ctrl
// Buffers branch resolutions from execute and forwards them to the branch
// predictor as updates, counts mispredicted updates, and runs a full-table
// invalidation sweep (BHT/BTB entry clears plus a RAS pointer reset) on a
// flush request.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   res_*                resolution input (valid/ready handshake)
//   upd_*                update output to the BPU (valid/ready handshake)
//   flush_req_i          single-cycle request to invalidate predictor state
//   flush_busy_o         sweep in progress
//   clr_vld_o/clr_idx_o  per-entry clear strobe and index
//   ras_clr_o            one-cycle RAS pointer reset
//   mis_cnt_o            saturating count of delivered mispredicted updates
//
// Optional feature: define K423_BPU_UPD_BYPASS_EN to forward a resolution
// straight to the update port when the FIFO is empty in IDLE.

`ifndef BR_TYPE_W
`define BR_TYPE_W 3
`endif
`ifndef CORE_DATA_W
`define CORE_DATA_W 32
`endif

module k423_if_bpu_upd_ctrl #(
    parameter int UPD_DEPTH = 4,
    parameter int TBL_IDX_W = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    res_vld_i,
    output logic                    res_rdy_o,
    input  logic                    res_tkn_i,
    input  logic                    res_mis_i,
    input  logic [`BR_TYPE_W-1:0]   res_type_i,
    input  logic [`CORE_DATA_W-1:0] res_src_pc_i,
    input  logic [`CORE_DATA_W-1:0] res_tgt_pc_i,
    input  logic [1:0]              res_sat_cnt_i,
    input  logic                    flush_req_i,
    output logic                    flush_busy_o,
    output logic                    upd_vld_o,
    output logic                    upd_tkn_o,
    output logic                    upd_mis_o,
    output logic [`BR_TYPE_W-1:0]   upd_type_o,
    output logic [`CORE_DATA_W-1:0] upd_src_pc_o,
    output logic [`CORE_DATA_W-1:0] upd_tgt_pc_o,
    output logic [1:0]              upd_sat_cnt_o,
    input  logic                    upd_rdy_i,
    output logic                    clr_vld_o,
    output logic [TBL_IDX_W-1:0]    clr_idx_o,
    output logic                    ras_clr_o,
    output logic [31:0]             mis_cnt_o
);

    localparam int AW    = $clog2(UPD_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    typedef struct packed {
        logic                    tkn;
        logic                    mis;
        logic [`BR_TYPE_W-1:0]   typ;
        logic [`CORE_DATA_W-1:0] src;
        logic [`CORE_DATA_W-1:0] tgt;
        logic [1:0]              sat;
    } upd_ent_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [TBL_IDX_W-1:0] sweep_idx;
    logic [31:0]          mis_cnt_q;
    upd_ent_t             mem [UPD_DEPTH];
    upd_ent_t             res_ent, head_ent, out_ent;
    logic                 fifo_empty, fifo_full;
    logic                 use_byp, push, pop, xfer, flush_go;

    assign res_ent = '{tkn: res_tkn_i, mis: res_mis_i, typ: res_type_i,
                       src: res_src_pc_i, tgt: res_tgt_pc_i, sat: res_sat_cnt_i};

    // Wrap bits differ with equal addresses -> full; fully equal -> empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_ent   = mem[rd_ptr[AW-1:0]];

    // Control state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        upd_vld_o    = 1'b0;
        res_rdy_o    = 1'b0;
        clr_vld_o    = 1'b0;
        ras_clr_o    = 1'b0;
        flush_busy_o = 1'b0;
        use_byp      = 1'b0;
        case (state)
            IDLE: begin
                upd_vld_o = !fifo_empty;
`ifdef K423_BPU_UPD_BYPASS_EN
                if (fifo_empty && res_vld_i && !flush_req_i && !rst_i) begin
                    upd_vld_o = 1'b1;
                    use_byp   = 1'b1;
                end
`endif
                // A pop in the same cycle frees the slot a full FIFO needs.
                res_rdy_o = !rst_i && !flush_req_i &&
                            (!fifo_full || (upd_vld_o && upd_rdy_i));
                if (flush_req_i) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                clr_vld_o    = 1'b1;
                ras_clr_o    = (sweep_idx == '0);
                flush_busy_o = 1'b1;
                if (sweep_idx == '1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                flush_busy_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer     = upd_vld_o && upd_rdy_i;
    assign pop      = xfer && !use_byp;
    // A bypassed resolution is only buffered if the BPU did not take it.
    assign push     = res_vld_i && res_rdy_o && !(use_byp && upd_rdy_i);
    assign flush_go = (state == IDLE) && flush_req_i;

    assign out_ent       = use_byp ? res_ent : head_ent;
    assign upd_tkn_o     = upd_vld_o & out_ent.tkn;
    assign upd_mis_o     = upd_vld_o & out_ent.mis;
    assign upd_type_o    = upd_vld_o ? out_ent.typ : '0;
    assign upd_src_pc_o  = upd_vld_o ? out_ent.src : '0;
    assign upd_tgt_pc_o  = upd_vld_o ? out_ent.tgt : '0;
    assign upd_sat_cnt_o = upd_vld_o ? out_ent.sat : '0;

    // FIFO storage, data only
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= res_ent;
        end
    end

    // FIFO pointers; a flush drops every buffered resolution as stale
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sweep index wraps back to zero as the last entry is cleared
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sweep_idx <= '0;
        end else if (state == SWEEP) begin
            sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Mispredict counter survives flushes; only reset clears it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mis_cnt_q <= '0;
        end else if (xfer && upd_mis_o) begin
            mis_cnt_q <= sat_inc(mis_cnt_q);
        end
    end

    assign clr_idx_o = sweep_idx;
    assign mis_cnt_o = mis_cnt_q;

endmodule

// File: doc/k423_if_bpu_upd_ctrl.md
K423_IF_BPU_UPD_CTRL -- requirements
Module: k423_if_bpu_upd_ctrl

Interface
REQ-001 Parameter UPD_DEPTH, default 4, meaning: update FIFO depth; power of two, at least 2.
REQ-002 Parameter TBL_IDX_W, default 6, meaning: BHT/BTB index width; the sweep covers 2**TBL_IDX_W entries.
REQ-003 clk_i  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 res_vld_i  in  1  branch resolution from execute is valid.
REQ-006 res_rdy_o  out  1  the controller accepts the resolution this cycle.
REQ-007 res_tkn_i, res_mis_i  in  1 each  resolved taken, mispredicted.
REQ-008 res_type_i  in  `BR_TYPE_W  branch type.
REQ-009 res_src_pc_i, res_tgt_pc_i  in  `CORE_DATA_W each  branch PC, resolved target.
REQ-010 res_sat_cnt_i  in  2  saturating counter carried with the prediction.
REQ-011 flush_req_i  in  1  single-cycle request to invalidate all predictor state (fence.i, context switch).
REQ-012 flush_busy_o  out  1  a flush sequence is in progress.
REQ-013 upd_vld_o, upd_tkn_o, upd_mis_o, upd_type_o, upd_src_pc_o, upd_tgt_pc_o, upd_sat_cnt_o  out  widths as res_*  update port to the BPU.
REQ-014 upd_rdy_i  in  1  BPU accepts the update; upd_vld_o and upd_rdy_i high together form a transfer.
REQ-015 clr_vld_o  out  1  clear one BHT/BTB entry this cycle.
REQ-016 clr_idx_o  out  TBL_IDX_W  index of the entry to clear.
REQ-017 ras_clr_o  out  1  single-cycle RAS pointer reset.
REQ-018 mis_cnt_o  out  32  count of mispredicted updates delivered to the BPU.

Function
REQ-019 FSM states: IDLE, SWEEP, DONE.
REQ-020 Transitions: IDLE->SWEEP on flush_req_i; SWEEP->DONE when clr_idx_o equals all-ones and is issued; DONE->IDLE unconditionally after one cycle.
REQ-021 Resolutions are written into a UPD_DEPTH-entry FIFO.
REQ-022 res_rdy_o = FIFO not full and state is IDLE and not flush_req_i.
REQ-023 In IDLE, upd_vld_o = FIFO not empty, and upd_* present the FIFO head.
REQ-024 The FIFO head pops on the upd_vld_o and upd_rdy_i handshake.
REQ-025 While upd_vld_o is high and upd_rdy_i is low, every upd_* output holds stable.
REQ-026 Simultaneous push and pop are supported when the FIFO is full; count is unchanged and res_rdy_o stays high, because the pop frees an entry first.
REQ-027 On flush_req_i in IDLE, all FIFO contents are discarded next cycle, because they are stale.
REQ-028 A transfer completing in that same cycle still counts.
REQ-029 In SWEEP, clr_vld_o=1 with clr_idx_o incrementing by 1 per cycle from 0; upd_vld_o=0 and res_rdy_o=0.
REQ-030 ras_clr_o pulses in the first SWEEP cycle.
REQ-031 flush_busy_o=1 in SWEEP and DONE.
REQ-032 flush_req_i during SWEEP or DONE is ignored.
REQ-033 Flush latency from flush_req_i to flush_busy_o falling is 2**TBL_IDX_W+2 cycles.
REQ-034 mis_cnt_o increments by 1 on each transfer with upd_mis_o=1.
REQ-035 mis_cnt_o saturates at 32'hFFFF_FFFF and is not cleared by flush.
REQ-036 FIFO pointers are log2(UPD_DEPTH)+1 bits with a wrap bit; full and empty are decided by comparing the wrap bits.

Reset
REQ-037 While rst_i is high: state IDLE, FIFO empty, and clr_idx_o, mis_cnt_o, and all upd_*, clr_vld_o, ras_clr_o, flush_busy_o are 0; res_rdy_o is 1 after reset is released.
REQ-038 Reset asserted mid-SWEEP aborts the sweep.
REQ-039 No clear resumes after reset is released.

Configuration
REQ-040 Macro K423_BPU_UPD_BYPASS_EN: when defined, in IDLE with the FIFO empty, a valid resolution drives upd_* combinationally in the same cycle.
REQ-041 With the bypass, the resolution enters the FIFO only if the BPU does not accept it in that cycle (upd_rdy_i low).
REQ-042 When the macro is undefined, every update has exactly 1 cycle of latency through the FIFO.
REQ-043 In both builds, update order equals resolution order.

Verification
REQ-044 Idle, upd_rdy_i=1, one resolution with src_pc=0x100, tgt=0x80, mis=1 -> upd_* match the resolution at cycle+1 (cycle+0 with bypass); mis_cnt_o=1.
REQ-045 upd_rdy_i=0, 5 back-to-back resolutions -> 4 accepted, res_rdy_o low on the 5th; release upd_rdy_i -> 4 updates delivered in order with no loss.
REQ-046 FIFO holds 2 entries, flush_req_i pulse -> entries discarded; clr_idx_o runs 0..63 on consecutive cycles; ras_clr_o pulses once; flush_busy_o is high for 65 cycles.
REQ-047 flush_req_i at SWEEP index 10 -> ignored; the sweep completes normally at index 63.
REQ-048 rst_i asserted at SWEEP index 20 -> all outputs 0 immediately; after release, state IDLE and no clr_vld_o.
REQ-049 Force mis_cnt_o to 32'hFFFF_FFFE, then 3 mispredicted transfers -> mis_cnt_o holds at 32'hFFFF_FFFF.
